// File: rtl/bshift_seq_if.sv
// Request/response handshake bundle for the multi-step shift controller.
// The master issues shift requests and consumes responses; the slave serves them.
interface bshift_seq_if #(
  parameter int W     = 4,
  parameter int AMT_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_val;
  logic [AMT_W-1:0] req_amt;
  logic             req_dir;
  logic [1:0]       req_mode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_res;
  logic             rsp_cout;
  logic [AMT_W-1:0] rsp_ones;
  logic             rsp_err;

  modport master (
    output req_valid, req_val, req_amt, req_dir, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_cout, rsp_ones, rsp_err
  );

  modport slave (
    input  req_valid, req_val, req_amt, req_dir, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_cout, rsp_ones, rsp_err
  );
endinterface

// File: rtl/bshift_seq.sv
// Multi-step controller around a single-step barrel shifter: one bit per step,
// each shifter result fed back as the next operand until the amount is used up.
module bshift_seq #(
  parameter int W      = 4,
  parameter int AMT_W  = 3,
  parameter int SH_LAT = 0
) (
  input  logic         clock,
  input  logic         reset,
  bshift_seq_if.slave  bus,
  output logic         busy,
  output logic [W-1:0] sh_val,
  output logic         sh_ssl,
  output logic         sh_i,
  input  logic [W-1:0] sh_res,
  input  logic         sh_o
);

  localparam int LAT_W = (SH_LAT > 0) ? $clog2(SH_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             cout_q, cout_d;
  logic [AMT_W-1:0] ones_q, ones_d;
  logic             err_q, err_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic fill;
  logic exp_o;
  logic lat_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      cout_q  <= 1'b0;
      ones_q  <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      cout_q  <= cout_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

  // Insert bit: rotate recycles the bit leaving, arith replicates the sign
  always_comb begin
    fill = 1'b0;
    unique case (mode_q)
      2'b00: fill = 1'b0;
      2'b01: fill = 1'b1;
      2'b10: fill = dir_q ? work_q[0] : work_q[W-1];
      2'b11: fill = dir_q ? work_q[W-1] : 1'b0;
      default: fill = 1'b0;
    endcase
  end

  assign exp_o    = dir_q ? work_q[0] : work_q[W-1];
  assign lat_last = (lat_q == LAT_W'(SH_LAT));

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    cout_d  = cout_q;
    ones_d  = ones_q;
    err_d   = err_q;
    lat_d   = lat_q;
    sh_val  = '0;
    sh_ssl  = 1'b0;
    sh_i    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          work_d  = bus.req_val;
          cnt_d   = bus.req_amt;
          dir_d   = bus.req_dir;
          mode_d  = bus.req_mode;
          cout_d  = 1'b0;
          ones_d  = '0;
          err_d   = 1'b0;
          lat_d   = '0;
          state_d = (bus.req_amt == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        sh_val = work_q;
        sh_ssl = dir_q;
        sh_i   = fill;
        if (lat_last) begin
          lat_d  = '0;
          work_d = sh_res;
          cout_d = sh_o;
          ones_d = ones_q + AMT_W'(sh_o);
          err_d  = err_q | (sh_o != exp_o);
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = DONE;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response fields read as zero outside DONE
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_res   = (state_q == DONE) ? work_q : '0;
  assign bus.rsp_cout  = (state_q == DONE) ? cout_q : 1'b0;
  assign bus.rsp_ones  = (state_q == DONE) ? ones_q : '0;
  assign bus.rsp_err   = (state_q == DONE) ? err_q : 1'b0;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bshift_seq.sv
// Directed bench for bshift_seq with a combinational single-step shifter model
// whose expelled bit can be inverted to provoke the consistency flag.
module tb_bshift_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       busy;
  logic [3:0] sh_val;
  logic       sh_ssl;
  logic       sh_i;
  logic [3:0] sh_res;
  logic       sh_o;
  logic       inv_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] shv [8];
  int nsh;

  bshift_seq_if #(.W(4), .AMT_W(3)) bus ();

  bshift_seq #(.W(4), .AMT_W(3), .SH_LAT(0)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus.slave),
    .busy   (busy),
    .sh_val (sh_val),
    .sh_ssl (sh_ssl),
    .sh_i   (sh_i),
    .sh_res (sh_res),
    .sh_o   (sh_o)
  );

  always #5 clock = ~clock;

  always_comb begin
    sh_res = sh_ssl ? {sh_i, sh_val[3:1]} : {sh_val[2:0], sh_i};
    sh_o   = (sh_ssl ? sh_val[0] : sh_val[3]) ^ inv_o;
  end

  task automatic start_req(input logic [3:0] v, input logic [2:0] a,
                           input logic d, input logic [1:0] m,
                           input bit hold, output int lat);
    int g;
    bus.req_val   = v;
    bus.req_amt   = a;
    bus.req_dir   = d;
    bus.req_mode  = m;
    bus.req_valid = 1'b1;
    nsh = 0;
    g = 0;
    while (!bus.req_ready && g < 100) begin
      @(posedge clock); #1;
      g++;
    end
    @(posedge clock); #1;
    if (!hold) bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      if (nsh < 8) begin
        shv[nsh] = sh_val;
        nsh++;
      end
      @(posedge clock); #1;
      lat++;
    end
    if (!bus.rsp_valid) lat = -1;
  endtask

  task automatic ack;
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'($urandom);
      bus.req_val   = 4'($urandom);
      bus.req_amt   = 3'($urandom);
      bus.req_dir   = 1'($urandom);
      bus.req_mode  = 2'($urandom);
      bus.rsp_ready = 1'($urandom);
      @(posedge clock); #1;
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_res, bus.rsp_cout, bus.rsp_ones,
           bus.rsp_err, busy, sh_val, sh_ssl, sh_i} !== '0) begin
        n_bad++;
        $display("FAIL reset_outs cyc%0d got busy=%b rv=%b res=%b shv=%b",
                 i, busy, bus.rsp_valid, bus.rsp_res, sh_val);
      end
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ready got %b want 1", bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset got ready=%b busy=%b want 1/0",
               bus.req_ready, busy);
    end
  endtask

  task automatic test_right_logical;
    int lat;
    logic [3:0] want [4];
    want[0] = 4'b1110; want[1] = 4'b0111;
    want[2] = 4'b0011; want[3] = 4'b0001;
    start_req(4'b1110, 3'd4, 1'b1, 2'b00, 1'b0, lat);
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL t2_latency got %0d want 5", lat);
    end
    n_cmp++;
    if (nsh !== 4) begin
      n_bad++;
      $display("FAIL t2_steps got %0d want 4", nsh);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (shv[i] !== want[i]) begin
        n_bad++;
        $display("FAIL t2_shval%0d got %b want %b", i, shv[i], want[i]);
      end
    end
    n_cmp++;
    if ({bus.rsp_res, bus.rsp_cout, bus.rsp_ones, bus.rsp_err}
        !== {4'b0000, 1'b1, 3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL t2_rsp got res=%b c=%b ones=%0d err=%b want 0000 1 3 0",
               bus.rsp_res, bus.rsp_cout, bus.rsp_ones, bus.rsp_err);
    end
    ack();
  endtask

  task automatic test_rotate_and_zero;
    int lat;
    start_req(4'b1001, 3'd1, 1'b0, 2'b10, 1'b0, lat);
    n_cmp++;
    if ({bus.rsp_res, bus.rsp_cout, bus.rsp_ones, bus.rsp_err}
        !== {4'b0011, 1'b1, 3'd1, 1'b0} || lat !== 2) begin
      n_bad++;
      $display("FAIL t3_rotl got res=%b c=%b ones=%0d lat=%0d want 0011 1 1 2",
               bus.rsp_res, bus.rsp_cout, bus.rsp_ones, lat);
    end
    ack();
    start_req(4'b1001, 3'd0, 1'b0, 2'b10, 1'b0, lat);
    n_cmp++;
    if ({bus.rsp_res, bus.rsp_cout, bus.rsp_ones}
        !== {4'b1001, 1'b0, 3'd0} || lat !== 1) begin
      n_bad++;
      $display("FAIL t3_amt0 got res=%b c=%b ones=%0d lat=%0d want 1001 0 0 1",
               bus.rsp_res, bus.rsp_cout, bus.rsp_ones, lat);
    end
    ack();
  endtask

  task automatic test_arith_and_ones;
    int lat;
    start_req(4'b1000, 3'd2, 1'b1, 2'b11, 1'b0, lat);
    n_cmp++;
    if ({bus.rsp_res, bus.rsp_cout, bus.rsp_ones, bus.rsp_err}
        !== {4'b1110, 1'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL t4_arith got res=%b c=%b ones=%0d err=%b want 1110 0 0 0",
               bus.rsp_res, bus.rsp_cout, bus.rsp_ones, bus.rsp_err);
    end
    ack();
    start_req(4'b0000, 3'd3, 1'b0, 2'b01, 1'b0, lat);
    n_cmp++;
    if ({bus.rsp_res, bus.rsp_cout, bus.rsp_ones, bus.rsp_err}
        !== {4'b0111, 1'b0, 3'd0, 1'b0} || lat !== 4) begin
      n_bad++;
      $display("FAIL t4_fill1 got res=%b c=%b ones=%0d lat=%0d want 0111 0 0 4",
               bus.rsp_res, bus.rsp_cout, bus.rsp_ones, lat);
    end
    ack();
  endtask

  task automatic test_back_to_back;
    int lat;
    int g;
    start_req(4'b0001, 3'd1, 1'b0, 2'b00, 1'b1, lat);
    bus.req_val  = 4'b1000;
    bus.req_amt  = 3'd1;
    bus.req_dir  = 1'b1;
    bus.req_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_res, bus.rsp_cout, bus.req_ready}
          !== {1'b1, 4'b0010, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL t5_hold%0d got rv=%b res=%b c=%b rdy=%b want 1 0010 0 0",
                 i, bus.rsp_valid, bus.rsp_res, bus.rsp_cout, bus.req_ready);
      end
      @(posedge clock); #1;
    end
    ack();
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_handshake got rdy=%b rv=%b want 1 0",
               bus.req_ready, bus.rsp_valid);
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_accept2 got busy=%b want 1", busy);
    end
    g = 0;
    while (!bus.rsp_valid && g < 20) begin
      @(posedge clock); #1;
      g++;
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 4'b0100) begin
      n_bad++;
      $display("FAIL t5_second got rv=%b res=%b want 1 0100",
               bus.rsp_valid, bus.rsp_res);
    end
    ack();
  endtask

  task automatic test_err_flag;
    int lat;
    int g;
    bus.req_val   = 4'b0101;
    bus.req_amt   = 3'd2;
    bus.req_dir   = 1'b1;
    bus.req_mode  = 2'b00;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    inv_o = 1'b1;
    @(posedge clock); #1;
    inv_o = 1'b0;
    g = 0;
    while (!bus.rsp_valid && g < 20) begin
      @(posedge clock); #1;
      g++;
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_res} !== {1'b1, 1'b1, 4'b0001}) begin
      n_bad++;
      $display("FAIL t6_err got rv=%b err=%b res=%b want 1 1 0001",
               bus.rsp_valid, bus.rsp_err, bus.rsp_res);
    end
    ack();
    start_req(4'b0101, 3'd2, 1'b1, 2'b00, 1'b0, lat);
    n_cmp++;
    if ({bus.rsp_err, bus.rsp_res, bus.rsp_cout, bus.rsp_ones}
        !== {1'b0, 4'b0001, 1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL t6_errclr got err=%b res=%b c=%b ones=%0d want 0 0001 0 1",
               bus.rsp_err, bus.rsp_res, bus.rsp_cout, bus.rsp_ones);
    end
    ack();
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    bus.req_val   = 4'b1111;
    bus.req_amt   = 3'd4;
    bus.req_dir   = 1'b1;
    bus.req_mode  = 2'b00;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (sh_val !== 4'b0111 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_step2 got shv=%b busy=%b want 0111 1", sh_val, busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, bus.rsp_valid, bus.req_ready, sh_val}
        !== {1'b0, 1'b0, 1'b1, 4'b0000}) begin
      n_bad++;
      $display("FAIL t6_abort got busy=%b rv=%b rdy=%b shv=%b want 0 0 1 0000",
               busy, bus.rsp_valid, bus.req_ready, sh_val);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid || busy) seen = 1'b1;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_norsp got activity=%b want 0", seen);
    end
  endtask

  initial begin
    reset         = 1'b0;
    inv_o         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_val   = '0;
    bus.req_amt   = '0;
    bus.req_dir   = 1'b0;
    bus.req_mode  = 2'b00;
    bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    test_right_logical();
    test_rotate_and_zero();
    test_arith_and_ones();
    test_back_to_back();
    test_err_flag();
    test_reset_mid_op();
    test_right_logical();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
